imu_seq_ctrl: RTL and testbench

- Sequences the raw IMU sample stream into fixed windows of SEQ_LEN samples and hands each window to the downstream sensor-fusion accelerator.
- Uses ping-pong buffering: capture into one buffer continues while the accelerator drains the other.
- Issues a per-window start pulse, streams the window over a valid/ready handshake, then waits for the accelerator's done before recycling the buffer.
- Sits between the IMU front end (and its monitor tap) and the accelerator input port.

---
 rtl/imu_seq_ctrl.sv | 172 +++++++++++++++++
 tb/tb_imu_seq_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imu_seq_ctrl.sv
// Groups the IMU sample stream into SEQ_LEN windows using two ping-pong buffers and streams each window to the fusion accelerator.
// Optional stall counter output (stall_cnt) is enabled by defining IMU_SEQ_STALL_CNT_EN.
module imu_seq_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int SEQ_LEN    = 16,
    parameter int SEQ_ID_W   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] imu_data,
    input  logic                  imu_valid,
    output logic                  imu_ready,
    output logic                  acc_start,
    output logic [SEQ_ID_W-1:0]   acc_seq_id,
    output logic [DATA_WIDTH-1:0] acc_data,
    output logic                  acc_valid,
    input  logic                  acc_ready,
    output logic                  acc_last,
    input  logic                  acc_done,
    output logic                  busy
`ifdef IMU_SEQ_STALL_CNT_EN
    ,
    output logic [15:0]           stall_cnt
`endif
);

    // state        | meaning
    // RD_IDLE      | waiting for buffer[rd_buf] to become FULL
    // RD_START     | one-cycle acc_start pulse for the window
    // RD_STREAM    | presenting buffer[rd_buf][rd_idx] on acc_data
    // RD_WAIT_DONE | window sent, holding buffer until acc_done

    localparam int IDX_W = $clog2(SEQ_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SEQ_LEN - 1);

    typedef enum logic [1:0] {BUF_EMPTY, BUF_FILLING, BUF_FULL, BUF_READING} buf_state_e;
    typedef enum logic [1:0] {RD_IDLE, RD_START, RD_STREAM, RD_WAIT_DONE} rd_state_e;

    buf_state_e            buf_state_q [2];
    buf_state_e            buf_state_d [2];
    rd_state_e             rd_state_q, rd_state_d;
    logic                  wr_buf_q, wr_buf_d;
    logic                  rd_buf_q, rd_buf_d;
    logic [IDX_W-1:0]      wr_idx_q, wr_idx_d;
    logic [IDX_W-1:0]      rd_idx_q, rd_idx_d;
    logic [SEQ_ID_W-1:0]   seq_id_q, seq_id_d;
    logic [DATA_WIDTH-1:0] buf_mem [2][SEQ_LEN];
    logic                  wr_accept;

    // Readiness depends only on registered buffer state, so acc_ready/acc_done never reach imu_ready.
    assign imu_ready  = !rst && enable &&
                        (buf_state_q[wr_buf_q] == BUF_EMPTY || buf_state_q[wr_buf_q] == BUF_FILLING);
    assign wr_accept  = imu_valid && imu_ready;
    assign acc_seq_id = seq_id_q;
    assign acc_data   = buf_mem[rd_buf_q][rd_idx_q];
    assign busy       = (buf_state_q[0] != BUF_EMPTY) || (buf_state_q[1] != BUF_EMPTY) ||
                        (rd_state_q != RD_IDLE);

    always_comb begin
        buf_state_d = buf_state_q;
        rd_state_d  = rd_state_q;
        wr_buf_d    = wr_buf_q;
        rd_buf_d    = rd_buf_q;
        wr_idx_d    = wr_idx_q;
        rd_idx_d    = rd_idx_q;
        seq_id_d    = seq_id_q;
        acc_start   = 1'b0;
        acc_valid   = 1'b0;
        acc_last    = 1'b0;

        // Writer only touches EMPTY/FILLING buffers and the reader only FULL/READING ones, so they never collide.
        if (wr_accept) begin
            if (wr_idx_q == LAST_IDX) begin
                buf_state_d[wr_buf_q] = BUF_FULL;
                wr_idx_d              = '0;
                wr_buf_d              = !wr_buf_q;
            end else begin
                buf_state_d[wr_buf_q] = BUF_FILLING;
                wr_idx_d              = wr_idx_q + 1'b1;
            end
        end

        case (rd_state_q)
            RD_IDLE: begin
                if (buf_state_q[rd_buf_q] == BUF_FULL) begin
                    buf_state_d[rd_buf_q] = BUF_READING;
                    rd_state_d            = RD_START;
                end
            end
            RD_START: begin
                acc_start  = 1'b1;
                rd_state_d = RD_STREAM;
            end
            RD_STREAM: begin
                acc_valid = 1'b1;
                acc_last  = (rd_idx_q == LAST_IDX);
                if (acc_ready) begin
                    if (rd_idx_q == LAST_IDX) begin
                        rd_state_d = RD_WAIT_DONE;
                    end else begin
                        rd_idx_d = rd_idx_q + 1'b1;
                    end
                end
            end
            RD_WAIT_DONE: begin
                if (acc_done) begin
                    buf_state_d[rd_buf_q] = BUF_EMPTY;
                    rd_buf_d              = !rd_buf_q;
                    rd_idx_d              = '0;
                    seq_id_d              = seq_id_q + 1'b1;
                    rd_state_d            = RD_IDLE;
                end
            end
            default: rd_state_d = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_state_q[0] <= BUF_EMPTY;
            buf_state_q[1] <= BUF_EMPTY;
            rd_state_q     <= RD_IDLE;
            wr_buf_q       <= 1'b0;
            rd_buf_q       <= 1'b0;
            wr_idx_q       <= '0;
            rd_idx_q       <= '0;
            seq_id_q       <= '0;
        end else begin
            buf_state_q <= buf_state_d;
            rd_state_q  <= rd_state_d;
            wr_buf_q    <= wr_buf_d;
            rd_buf_q    <= rd_buf_d;
            wr_idx_q    <= wr_idx_d;
            rd_idx_q    <= rd_idx_d;
            seq_id_q    <= seq_id_d;
        end
    end

    // Sample storage needs no reset; the buffer state words decide what is valid.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            buf_mem[wr_buf_q][wr_idx_q] <= imu_data;
        end
    end

`ifdef IMU_SEQ_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic        stall_inc;

    always_comb begin
        stall_inc   = imu_valid && !imu_ready && enable && (stall_cnt_q != 16'hFFFF);
        stall_cnt_d = stall_inc ? stall_cnt_q + 16'd1 : stall_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            if (stall_inc) begin
                $display("imu_seq_ctrl stall_cnt=%0d", stall_cnt_d);
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    // Stall cycles are not counted in this build.
`endif

endmodule

// File: tb/tb_imu_seq_ctrl.sv
// Scoreboard bench for imu_seq_ctrl: accepted samples are queued and checked against the accelerator stream,
// with a window-level model of readiness, start timing, sequence ids and busy.
module tb_imu_seq_ctrl;
    localparam int DW = 16;
    localparam int L  = 16;
    localparam int IW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic [DW-1:0] imu_data = '0;
    logic          imu_valid = 1'b0;
    logic          acc_ready = 1'b0;
    logic          acc_done = 1'b0;
    logic          imu_ready, acc_start, acc_valid, acc_last, busy;
    logic [IW-1:0] acc_seq_id;
    logic [DW-1:0] acc_data;
`ifdef IMU_SEQ_STALL_CNT_EN
    logic [15:0]   stall_cnt;
`endif

    imu_seq_ctrl #(.DATA_WIDTH(DW), .SEQ_LEN(L), .SEQ_ID_W(IW)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .imu_data   (imu_data),
        .imu_valid  (imu_valid),
        .imu_ready  (imu_ready),
        .acc_start  (acc_start),
        .acc_seq_id (acc_seq_id),
        .acc_data   (acc_data),
        .acc_valid  (acc_valid),
        .acc_ready  (acc_ready),
        .acc_last   (acc_last),
        .acc_done   (acc_done),
        .busy       (busy)
`ifdef IMU_SEQ_STALL_CNT_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit checking = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Reference model: A accepted samples, S windows started, H samples handed over, R windows released.
    logic [DW-1:0] exp_q[$];
    int            cmpl_q[$];
    int            A, S, H, R, rel_cyc, cur_start, start_at;
    bit            rdy_e, val_e, start_e;
    int            stall_exp;

    task automatic model_reset();
        exp_q.delete();
        cmpl_q.delete();
        A = 0; S = 0; H = 0; R = 0;
        rel_cyc = -100; cur_start = 0; stall_exp = 0;
    endtask

    always @(negedge clk) begin
        cyc++;
        if (checking) begin
            rdy_e   = !rst && enable && ((A / L - R) < 2);
            val_e   = (S > R) && (cyc > cur_start) && (H < S * L);
            start_e = 1'b0;
            if (S == R && cmpl_q.size() > 0) begin
                start_at = ((cmpl_q[0] > rel_cyc) ? cmpl_q[0] : rel_cyc) + 2;
                start_e  = (cyc >= start_at);
            end
            chk("imu_ready",  32'(imu_ready),  32'(rdy_e));
            chk("busy",       32'(busy),       32'(A != R * L));
            chk("acc_seq_id", 32'(acc_seq_id), 32'(R % 256));
            chk("acc_start",  32'(acc_start),  32'(start_e));
            chk("acc_valid",  32'(acc_valid),  32'(val_e));
            if (val_e && exp_q.size() > 0) begin
                chk("acc_data", 32'(acc_data), 32'(exp_q[0]));
                chk("acc_last", 32'(acc_last), 32'((H % L) == L - 1));
            end else begin
                chk("acc_last_idle", 32'(acc_last), 32'(0));
            end
`ifdef IMU_SEQ_STALL_CNT_EN
            chk("stall_cnt", 32'(stall_cnt), 32'(stall_exp));
`endif
            if (rst) begin
                model_reset();
            end else begin
`ifdef IMU_SEQ_STALL_CNT_EN
                if (imu_valid && !rdy_e && enable && stall_exp < 65535) stall_exp++;
`endif
                if (acc_done && S > R && H == S * L) begin
                    R++;
                    rel_cyc = cyc;
                end
                if (val_e && acc_ready && exp_q.size() > 0) begin
                    void'(exp_q.pop_front());
                    H++;
                end
                if (start_e) begin
                    S++;
                    cur_start = cyc;
                    void'(cmpl_q.pop_front());
                end
                if (imu_valid && rdy_e) begin
                    exp_q.push_back(imu_data);
                    A++;
                    if (A % L == 0) cmpl_q.push_back(cyc);
                end
            end
        end else if (rst) begin
            model_reset();
            checking = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] d, input int budget);
        bit done_flag;
        done_flag = 1'b0;
        imu_valid = 1'b1;
        imu_data  = d;
        for (int i = 0; i < budget && !done_flag; i++) begin
            @(negedge clk);
            done_flag = imu_valid && imu_ready;
            tick();
        end
        imu_valid = 1'b0;
        if (!done_flag) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout sample %0h not accepted within %0d cycles", d, budget);
        end
    endtask

    task automatic wait_valid(input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            seen = acc_valid;
        end
        tick();
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_valid_timeout acc_valid low for %0d cycles", budget);
        end
    endtask

    task automatic pulse_done();
        acc_done = 1'b1;
        tick();
        acc_done = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick();
        rst = 1'b0;
        enable = 1'b1;
        acc_ready = 1'b1;
        tick();

        // One window 1..16 with the accelerator always ready, then done in WAIT_DONE and a stray done in IDLE.
        for (int i = 1; i <= L; i++) send(DW'(i), 50);
        repeat (24) tick();
        pulse_done();
        repeat (3) tick();
        pulse_done();
        repeat (3) tick();

        // Accelerator stalled while 40 samples are offered; the third window waits for the first release.
        acc_ready = 1'b0;
        fork
            begin
                for (int i = 1; i <= 40; i++) send(DW'(i), 200);
            end
            begin
                repeat (50) tick();
                acc_ready = 1'b1;
                repeat (25) tick();
                pulse_done();
                repeat (25) tick();
                pulse_done();
            end
        join
        repeat (2) tick();

        // Complete the partial window and wiggle acc_ready while it streams.
        acc_ready = 1'b0;
        for (int i = 41; i <= 48; i++) send(DW'(i), 50);
        wait_valid(50);
        acc_ready = 1'b1; tick();
        acc_ready = 1'b0; tick();
        tick();
        acc_ready = 1'b1;
        repeat (20) tick();
        pulse_done();
        repeat (3) tick();

        // Reset with a partial window, then again in the middle of streaming a full one.
        for (int i = 0; i < 7; i++) send(DW'($urandom), 50);
        rst = 1'b1; tick();
        rst = 1'b0; tick();
        for (int i = 0; i < L; i++) send(DW'($urandom), 50);
        wait_valid(50);
        repeat (5) tick();
        rst = 1'b1; tick();
        rst = 1'b0; tick();
        for (int i = 0; i < L; i++) send(DW'($urandom), 50);
        repeat (22) tick();
        pulse_done();
        repeat (3) tick();

        // Random traffic with stalls, enable drops and stray done pulses.
        for (int i = 0; i < 2000; i++) begin
            imu_valid = ($urandom % 4) != 0;
            imu_data  = DW'($urandom);
            enable    = ($urandom % 10) != 0;
            acc_ready = ($urandom % 3) != 0;
            acc_done  = ($urandom % 6) == 0;
            tick();
        end
        imu_valid = 1'b0;
        enable    = 1'b1;
        acc_ready = 1'b1;
        acc_done  = 1'b1;
        repeat (80) tick();
        acc_done  = 1'b0;
        repeat (5) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
